degrees: RTL and testbench

DEGREES -- requirements
Module: degrees

---
 rtl/degrees_pkg.sv | 22 ++
 rtl/degrees_seq_mul.sv | 49 ++++
 rtl/degrees.sv | 131 +++++++++++++
 tb/tb_degrees.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/degrees_pkg.sv
// Shared math constants and the state encoding for the radians-to-degrees block.
package degrees_pkg;

   localparam int FLOAT_BITS        = 32;
   localparam int FLOAT_DCM_BITS    = 16;
   localparam int FLOAT_DOUBLE_BITS = 2 * FLOAT_BITS;
   localparam int INT_BITS          = 16;

   // Fixed-point constants with FLOAT_DCM_BITS fraction bits, rounded to nearest.
   localparam logic [FLOAT_BITS-1:0] PI      = 32'd205887;   // pi
   localparam logic [FLOAT_BITS-1:0] INV_180 = 32'd364;      // 1/180
   localparam logic [FLOAT_BITS-1:0] RAD2DEG = 32'd3754936;  // 180/pi

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_ROUND,
      ST_WRAP,
      ST_DONE
   } state_t;

endpackage

// File: rtl/degrees_seq_mul.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle, FLOAT_BITS cycles.
module seq_mul
   import degrees_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start_i,
   input  logic [FLOAT_BITS-1:0]        a_i,
   input  logic [FLOAT_BITS-1:0]        b_i,
   output logic                         done_o,
   output logic [FLOAT_DOUBLE_BITS-1:0] product_o
);

   localparam int CNT_W = $clog2(FLOAT_BITS);

   logic [FLOAT_DOUBLE_BITS-1:0] mcand_q;
   logic [FLOAT_DOUBLE_BITS-1:0] acc_q;
   logic [FLOAT_BITS-1:0]        mplier_q;
   logic [CNT_W-1:0]             cnt_q;
   logic                         busy_q;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (start_i) begin
         mcand_q  <= {{FLOAT_BITS{1'b0}}, a_i};
         mplier_q <= b_i;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         if (mplier_q[0]) acc_q <= acc_q + mcand_q;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
         if (cnt_q == CNT_W'(FLOAT_BITS - 1)) busy_q <= 1'b0;
      end
   end

   // Flags the cycle whose edge folds in the last partial product.
   assign done_o    = busy_q && (cnt_q == CNT_W'(FLOAT_BITS - 1));
   assign product_o = acc_q;

endmodule

// File: rtl/degrees.sv
// Converts a fixed-point angle in radians to integer degrees, either wrapped
// to [0,360) or saturated to the signed INT_BITS range, with fixed latency.
module degrees
   import degrees_pkg::*;
#(
   parameter bit WRAP = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [FLOAT_BITS-1:0] in,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic signed [INT_BITS-1:0] out,
   output logic                       out_valid,
   input  logic                       out_ready
);

   localparam int MAG_BITS = FLOAT_DOUBLE_BITS - 2 * FLOAT_DCM_BITS + 1;
   localparam int REM_BITS = MAG_BITS + INT_BITS;
   localparam int CNT_W    = $clog2(INT_BITS);

   localparam logic [MAG_BITS-1:0]          DEG_FULL    = MAG_BITS'(360);
   localparam logic [MAG_BITS-1:0]          SAT_POS     = (MAG_BITS'(1) << (INT_BITS - 1)) - 1'b1;
   localparam logic [MAG_BITS-1:0]          SAT_NEG_MAG = MAG_BITS'(1) << (INT_BITS - 1);
   localparam logic [FLOAT_DOUBLE_BITS:0]   HALF_LSB    = (FLOAT_DOUBLE_BITS + 1)'(1) << (2 * FLOAT_DCM_BITS - 1);

   state_t                state_q;
   logic                  neg_q;
   logic [MAG_BITS-1:0]   mag_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [INT_BITS-1:0]   out_q;
   logic                  ready_q;
   logic                  valid_q;

   logic                         start;
   logic [FLOAT_BITS-1:0]        abs_in;
   logic                         mul_done;
   logic [FLOAT_DOUBLE_BITS-1:0] product;
   logic [MAG_BITS-1:0]          rounded;
   logic [REM_BITS-1:0]          trial;
   logic [MAG_BITS-1:0]          rem_d;
   logic [INT_BITS-1:0]          sat_val;
   logic [INT_BITS-1:0]          out_d;

   assign start  = (state_q == ST_IDLE) && in_valid;
   // Unsigned two's-complement negate keeps the most negative input exact.
   assign abs_in = in[FLOAT_BITS-1] ? (~in + 1'b1) : in;

   seq_mul u_mul (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start),
      .a_i       (abs_in),
      .b_i       (RAD2DEG),
      .done_o    (mul_done),
      .product_o (product)
   );

   // Adding half an LSB then truncating rounds the magnitude half away from zero.
   assign rounded = MAG_BITS'(({1'b0, product} + HALF_LSB) >> (2 * FLOAT_DCM_BITS));

   // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
   always_comb begin
      trial = REM_BITS'(DEG_FULL) << cnt_q;
      rem_d = mag_q;
      if (WRAP && (REM_BITS'(mag_q) >= trial)) rem_d = mag_q - MAG_BITS'(trial);

      if (neg_q) sat_val = (mag_q >= SAT_NEG_MAG) ? INT_BITS'(SAT_NEG_MAG) : INT_BITS'(~mag_q + 1'b1);
      else       sat_val = (mag_q > SAT_POS) ? INT_BITS'(SAT_POS) : INT_BITS'(mag_q);

      if (WRAP) out_d = INT_BITS'((neg_q && (rem_d != '0)) ? (DEG_FULL - rem_d) : rem_d);
      else      out_d = sat_val;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         neg_q   <= 1'b0;
         mag_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  neg_q   <= in[FLOAT_BITS-1];
                  ready_q <= 1'b0;
                  state_q <= ST_MUL;
               end
            end
            ST_MUL: begin
               if (mul_done) state_q <= ST_ROUND;
            end
            ST_ROUND: begin
               mag_q   <= rounded;
               cnt_q   <= CNT_W'(INT_BITS - 1);
               state_q <= ST_WRAP;
            end
            ST_WRAP: begin
               mag_q <= rem_d;
               if (cnt_q == '0) begin
                  out_q   <= out_d;
                  valid_q <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = ready_q;
   assign out_valid = valid_q;
   assign out       = out_q;

endmodule

// File: tb/tb_degrees.sv
// Drives a wrapping and a saturating instance in lock-step and compares them
// against an arithmetic model of round(degrees(x)).
module tb_degrees;
   import degrees_pkg::*;

   localparam int LATENCY = FLOAT_BITS + INT_BITS + 1;

   logic                        clk = 1'b0;
   logic                        rst;
   logic signed [FLOAT_BITS-1:0] in;
   logic                        in_valid;
   logic                        out_ready;
   logic                        in_ready_w, out_valid_w, in_ready_s, out_valid_s;
   logic signed [INT_BITS-1:0]  out_w, out_s;

   int checks = 0;
   int errors = 0;
   int pi_i;

   always #5 clk = ~clk;

   degrees #(.WRAP(1'b1)) dut_w (
      .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready_w),
      .out(out_w), .out_valid(out_valid_w), .out_ready(out_ready)
   );

   degrees #(.WRAP(1'b0)) dut_s (
      .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready_s),
      .out(out_s), .out_valid(out_valid_s), .out_ready(out_ready)
   );

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // round(|x| * 180/pi) using the quantised constant, by integer division.
   function automatic longint round_deg(input longint x);
      longint m, p, one;
      one = longint'(1) << (2 * FLOAT_DCM_BITS);
      m = (x < 0) ? -x : x;
      p = m * longint'(RAD2DEG);
      return (p + one / 2) / one;
   endfunction

   function automatic longint model_wrap(input longint x);
      longint r;
      r = round_deg(x) % 360;
      if (x < 0 && r != 0) r = 360 - r;
      return r;
   endfunction

   function automatic longint model_sat(input longint x);
      longint v, lo, hi;
      hi = (longint'(1) << (INT_BITS - 1)) - 1;
      lo = -(longint'(1) << (INT_BITS - 1));
      v = (x < 0) ? -round_deg(x) : round_deg(x);
      if (v > hi) v = hi;
      if (v < lo) v = lo;
      return v;
   endfunction

   task automatic run_op(input logic signed [FLOAT_BITS-1:0] x, input bit junk,
                         output longint ow, output longint os);
      int n, lat;
      bit seen;
      n = 0;
      while (!in_ready_w && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_op", in_ready_w, 1);
      @(negedge clk);
      in = x;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 200) begin
         @(posedge clk);
         #1 lat++;
         if (junk && lat == 10) begin in = $signed(PI); in_valid = 1'b1; end
         if (junk && lat == 12) begin in = -32'sd7; end
         if (junk && lat == 14) in_valid = 1'b0;
         if (junk && lat == 40) in_valid = 1'b1;
         if (junk && lat == 41) in_valid = 1'b0;
         seen = out_valid_w;
      end
      check("latency", lat, LATENCY);
      check("lockstep_valid", out_valid_s, 1);
      ow = out_w;
      os = out_s;
      check("wrap_vs_model", ow, model_wrap(x));
      check("sat_vs_model", os, model_sat(x));
   endtask

   task automatic retire();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("retire_ready", in_ready_w, 1);
      check("retire_valid", out_valid_w, 0);
   endtask

   initial begin : stimulus
      longint ow, os;
      bit leaked;
      pi_i      = int'(PI);
      rst       = 1'b1;
      in        = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;

      #12;
      check("reset_in_ready_w", in_ready_w, 1);
      check("reset_out_valid_w", out_valid_w, 0);
      check("reset_out_w", out_w, 0);
      check("reset_in_ready_s", in_ready_s, 1);
      check("reset_out_s", out_s, 0);
      @(negedge clk);
      rst = 1'b0;

      run_op(0, 1'b0, ow, os);
      check("zero_w", ow, 0);
      check("zero_s", os, 0);
      retire();

      run_op(pi_i, 1'b0, ow, os);
      check("pi_w", ow, 180);
      check("pi_s", os, 180);
      retire();

      run_op(-(pi_i / 2), 1'b0, ow, os);
      check("neg_half_pi_w", ow, 270);
      check("neg_half_pi_s", os, -90);
      retire();

      run_op(2 * pi_i, 1'b0, ow, os);
      check("two_pi_w", ow, 0);
      check("two_pi_s", os, 360);
      retire();

      run_op(-2 * pi_i, 1'b0, ow, os);
      check("neg_two_pi_w", ow, 0);
      check("neg_two_pi_s", os, -360);
      retire();

      // Result must hold under back-pressure, despite in_valid pulses mid-flight.
      run_op(pi_i / 3, 1'b1, ow, os);
      check("junk_ignored_w", ow, 60);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("hold_out_w", out_w, ow);
         check("hold_valid_w", out_valid_w, 1);
         check("hold_out_s", out_s, os);
         check("hold_busy", in_ready_w, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      in = $signed(PI);
      in_valid = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      in_valid = 1'b0;
      check("no_accept_on_retire", in_ready_w, 1);
      check("no_accept_valid", out_valid_w, 0);

      // Reset in the middle of the multiply discards the operand.
      @(negedge clk);
      in = $signed(PI);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (FLOAT_BITS / 2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_in_ready", in_ready_w, 1);
      check("midrst_out_valid", out_valid_w, 0);
      check("midrst_out", out_w, 0);
      check("midrst_out_s", out_s, 0);
      @(negedge clk);
      rst = 1'b0;
      leaked = 1'b0;
      for (int i = 0; i < LATENCY + 10; i++) begin
         @(negedge clk);
         if (out_valid_w || out_valid_s) leaked = 1'b1;
      end
      check("midrst_no_partial", leaked, 0);
      run_op(pi_i, 1'b0, ow, os);
      check("after_rst_pi", ow, 180);
      retire();

      run_op(32'sh8000_0000, 1'b0, ow, os);
      check("most_neg_s", os, -32768);
      retire();

      run_op(32'sh7FFF_FFFF, 1'b0, ow, os);
      check("most_pos_s", os, 32767);
      retire();

      for (int i = 0; i < 16; i++) begin
         logic signed [FLOAT_BITS-1:0] x;
         if (i[0]) x = $signed($urandom);
         else      x = $signed(32'($urandom_range(0, 4000000))) - 32'sd2000000;
         run_op(x, 1'b0, ow, os);
         retire();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
